pipe_scheduler: RTL

Game-clock controller that owns the two pipe obstacles and the score. It advances pipe positions while play is enabled and respawns each pipe at the right edge with a pseudo-random gap height. It detects the bird clearing each pipe and keeps a 3-digit BCD score. It replaces the ad-hoc pipe-position logic in the top level and feeds `collision_detector`, `display_manager` and the HEX scoreboard.

---
 rtl/flappy_pkg.sv | 41 ++++
 rtl/pipe_scheduler_bcd_score_counter.sv | 22 ++
 rtl/pipe_scheduler.sv | 115 +++++++++++
 3 files changed

// File: rtl/flappy_pkg.sv
// rtl/flappy_pkg.sv - shared types and constants for the flappy game blocks
// Holds the coordinate/score types, the scheduler state encoding, the default
// screen width with the pipe start positions, and the BCD increment helper.
package flappy_pkg;

   typedef logic [10:0] coord_t;
   typedef logic [11:0] bcd3_t;

   typedef enum logic [1:0] {
      READY = 2'd0,
      RUN   = 2'd1,
      HALT  = 2'd2
   } sched_state_e;

   localparam int     SCREEN_W      = 640;
   localparam coord_t PIPE1_START_X = coord_t'(SCREEN_W / 2 - 1);
   localparam coord_t PIPE1_START_Y = 11'd250;
   localparam coord_t PIPE2_START_X = coord_t'(SCREEN_W - 1);
   localparam coord_t PIPE2_START_Y = 11'd200;

   // Increment a 3-digit BCD value with carry; 999 holds.
   function automatic bcd3_t bcd_inc(input bcd3_t v);
      bcd3_t r;
      r = v;
      if (v != 12'h999) begin
         if (v[3:0] != 4'd9) begin
            r[3:0] = v[3:0] + 4'd1;
         end else begin
            r[3:0] = 4'd0;
            if (v[7:4] != 4'd9) begin
               r[7:4] = v[7:4] + 4'd1;
            end else begin
               r[7:4]  = 4'd0;
               r[11:8] = v[11:8] + 4'd1;
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/pipe_scheduler_bcd_score_counter.sv
// rtl/pipe_scheduler_bcd_score_counter.sv - saturating 3-digit BCD score counter
// Ports: clk, reset (sync, active-high), clear (sync zero), inc (count one),
//        count (12-bit {hundreds, tens, ones}).
import flappy_pkg::*;

module bcd_score_counter (
   input  logic  clk,
   input  logic  reset,
   input  logic  clear,
   input  logic  inc,
   output bcd3_t count
);

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= 12'h000;
      end else if (inc) begin
         count <= bcd_inc(count);
      end
   end

endmodule

// File: rtl/pipe_scheduler.sv
// rtl/pipe_scheduler.sv - pipe obstacle movement, respawn and score keeping
// Ports: game_clk, reset (sync, active-high), restart (level, back to READY),
//        enable (play enable); pipe1_x/y, pipe2_x/y (11-bit position / gap y),
//        score_bcd (3-digit BCD), score_tick (pulse per point),
//        respawn ([0]=pipe1, [1]=pipe2 pulses), running (high in RUN).
import flappy_pkg::*;

module pipe_scheduler #(
   parameter int          SCREEN_W  = flappy_pkg::SCREEN_W,
   parameter int          SPEED     = 1,
   parameter int          BIRD_X    = 100,
   parameter int          GAP_MIN   = 120,
   parameter int          GAP_RANGE = 240,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic         game_clk,
   input  logic         reset,
   input  logic         restart,
   input  logic         enable,
   output coord_t       pipe1_x,
   output coord_t       pipe1_y,
   output coord_t       pipe2_x,
   output coord_t       pipe2_y,
   output bcd3_t        score_bcd,
   output logic         score_tick,
   output logic [1:0]   respawn,
   output logic         running
);

   localparam coord_t SPEED_C     = coord_t'(SPEED);
   localparam coord_t BIRD_C      = coord_t'(BIRD_X);
   localparam coord_t GAP_MIN_C   = coord_t'(GAP_MIN);
   localparam coord_t GAP_RANGE_C = coord_t'(GAP_RANGE);
   localparam coord_t RESPAWN_X   = coord_t'(SCREEN_W - 1);
   localparam coord_t P1_X0       = coord_t'(SCREEN_W / 2 - 1);

   sched_state_e state, state_next;
   logic [15:0]  lfsr;
   logic         pending;
   logic         move;
   logic         resp1, resp2, sc1, sc2, inc, pending_next;
   coord_t       p1_x_nxt, p2_x_nxt;

   // Values above the range wrap back to the bottom so every byte maps to a gap.
   function automatic coord_t gap_y(input logic [7:0] r);
      coord_t rv;
      rv = {3'b000, r};
      return (rv <= GAP_RANGE_C) ? GAP_MIN_C + rv : GAP_MIN_C + rv - GAP_RANGE_C - 11'd1;
   endfunction

   always_comb begin
      state_next = state;
      case (state)
         READY:   if (enable)  state_next = RUN;
         RUN:     if (!enable) state_next = HALT;
         HALT:    state_next = HALT;
         default: state_next = READY;
      endcase
      if (restart) state_next = READY;
   end

   // Movement is tied to the next state so the entering edge already moves.
   assign move = (state_next == RUN);

   // Compare before subtracting so x never wraps below zero.
   assign resp1    = move && (pipe1_x < SPEED_C);
   assign resp2    = move && (pipe2_x < SPEED_C);
   assign p1_x_nxt = resp1 ? RESPAWN_X : (move ? pipe1_x - SPEED_C : pipe1_x);
   assign p2_x_nxt = resp2 ? RESPAWN_X : (move ? pipe2_x - SPEED_C : pipe2_x);
   assign sc1      = move && !resp1 && (pipe1_x > BIRD_C) && (p1_x_nxt <= BIRD_C);
   assign sc2      = move && !resp2 && (pipe2_x > BIRD_C) && (p2_x_nxt <= BIRD_C);

   // One point per cycle; any second concurrent event is deferred one cycle.
   assign inc          = !restart && (sc1 || sc2 || pending);
   assign pending_next = (sc1 && sc2) || (pending && (sc1 || sc2));

   always_ff @(posedge game_clk) begin
      if (reset) begin
         lfsr <= LFSR_SEED;
      end else begin
         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      end

      if (reset || restart) begin
         state      <= READY;
         running    <= 1'b0;
         pipe1_x    <= P1_X0;
         pipe1_y    <= PIPE1_START_Y;
         pipe2_x    <= RESPAWN_X;
         pipe2_y    <= PIPE2_START_Y;
         pending    <= 1'b0;
         score_tick <= 1'b0;
         respawn    <= 2'b00;
      end else begin
         state      <= state_next;
         running    <= (state_next == RUN);
         pipe1_x    <= p1_x_nxt;
         pipe2_x    <= p2_x_nxt;
         if (resp1) pipe1_y <= gap_y(lfsr[7:0]);
         if (resp2) pipe2_y <= gap_y(lfsr[15:8]);
         pending    <= pending_next;
         score_tick <= inc;
         respawn    <= {resp2, resp1};
      end
   end

   bcd_score_counter u_score (
      .clk   (game_clk),
      .reset (reset),
      .clear (restart),
      .inc   (inc),
      .count (score_bcd)
   );

endmodule
